// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder and its FIFOs.
package spi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam int SPI_BYTE_W  = 8;
  localparam int SYNC_STAGES = 2;

  localparam logic [SPI_BYTE_W-1:0] FILL_DEFAULT = 8'h00;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock show-ahead FIFO. The head word is visible on o_dout without a read.
// Reads of an empty FIFO and writes to a full FIFO are ignored, except that a
// write is accepted while full if a read frees a slot in the same cycle.
module fifo_sync #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_wrreq,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_rdreq,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_empty,
  output logic              o_full,
  output logic [CW-1:0]     o_usedw
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_cnt;
  logic              w_rd;
  logic              w_wr;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_usedw = r_cnt;
  assign w_rd    = i_rdreq & ~o_empty;
  assign w_wr    = i_wrreq & (~o_full | w_rd);
  // Empty FIFO presents zero rather than stale storage.
  assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 responder: oversamples sclk/n_cs/mosi in the clk domain,
// deserialises MOSI into an RX FIFO and serialises TX FIFO bytes onto MISO.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int                    DEPTH = 16,
  parameter logic [SPI_BYTE_W-1:0] FILL  = FILL_DEFAULT
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  sclk,
  input  logic                  n_cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [SPI_BYTE_W-1:0] tx_din,
  input  logic                  tx_wrreq,
  output logic                  tx_full,
  output logic [SPI_BYTE_W-1:0] rx_dout,
  input  logic                  rx_rdreq,
  output logic                  have_msg,
  output logic [7:0]            len,
  output logic [1:0]            err
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Synchronisers and edge-detect registers
  logic [SYNC_STAGES-1:0] r_sclk_s;
  logic [SYNC_STAGES-1:0] r_cs_s;
  logic [SYNC_STAGES-1:0] r_mosi_s;
  logic                   r_sclk_d;
  logic                   r_cs_d;
  logic                   w_sclk_rise;
  logic                   w_sclk_fall;
  logic                   w_cs_rise;
  logic                   w_cs_fall;
  logic                   w_mosi;

  // FSM and transfer control
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_start;
  logic                   w_end;
  logic                   w_do_rise;
  logic                   w_do_fall;
  logic                   w_load;
  logic [2:0]             r_bitcnt;
  logic                   r_armed;
  logic                   r_pend_pop;
  logic                   r_pend_unr;
  logic                   r_frame_pushed;
  logic                   r_frame_done;
  logic                   r_miso_en;
  logic                   r_err_ovf;
  logic                   r_err_unr;
  logic                   r_have_msg;
  logic [SPI_BYTE_W-1:0]  r_tx_sr;
  logic [SPI_BYTE_W-1:0]  r_rx_sr;
  logic [SPI_BYTE_W-1:0]  w_rx_byte;

  // FIFO interfaces
  logic                   w_rx_push;
  logic                   w_rx_rd;
  logic                   w_rx_wr_ok;
  logic                   w_rx_empty;
  logic                   w_rx_full;
  logic [CW-1:0]          w_rx_usedw;
  logic [CW-1:0]          w_len_nxt;
  logic                   w_tx_rd;
  logic                   w_tx_empty;
  logic [SPI_BYTE_W-1:0]  w_tx_head;
  logic [CW-1:0]          w_tx_usedw;
  logic                   w_unused;

  assign w_sclk_rise = r_sclk_s[SYNC_STAGES-1] & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_s[SYNC_STAGES-1] & r_sclk_d;
  assign w_cs_rise   = r_cs_s[SYNC_STAGES-1] & ~r_cs_d;
  assign w_cs_fall   = ~r_cs_s[SYNC_STAGES-1] & r_cs_d;
  assign w_mosi      = r_mosi_s[SYNC_STAGES-1];

  // Bring the SPI pins into the clk domain; n_cs idles high.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sclk_s <= '0;
      r_cs_s   <= '1;
      r_mosi_s <= '0;
      r_sclk_d <= 1'b0;
      r_cs_d   <= 1'b1;
    end else begin
      r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], sclk};
      r_cs_s   <= {r_cs_s[SYNC_STAGES-2:0], n_cs};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], mosi};
      r_sclk_d <= r_sclk_s[SYNC_STAGES-1];
      r_cs_d   <= r_cs_s[SYNC_STAGES-1];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and per-cycle transfer strobes. A falling sclk is only
  // honoured after a rise in this frame, so an sclk already high when n_cs
  // falls is not treated as an edge.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end       = 1'b0;
    w_do_rise   = 1'b0;
    w_do_fall   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_start     = 1'b1;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (w_cs_rise) begin
          w_end       = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_do_rise = w_sclk_rise;
          w_do_fall = w_sclk_fall & r_armed;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A new TX byte is loaded at frame start and at each byte-boundary fall.
  // The FIFO pop (or the underrun flag for a FILL byte) is committed on the
  // next sclk rise, i.e. only once the master actually clocks that byte, so
  // the trailing fall before n_cs rises neither consumes data nor flags an
  // underrun.
  assign w_load    = w_start | (w_do_fall & (r_bitcnt == 3'd0));
  assign w_rx_byte = {r_rx_sr[SPI_BYTE_W-2:0], w_mosi};
  assign w_rx_push = w_do_rise & (r_bitcnt == 3'd7);
  assign w_rx_rd   = rx_rdreq & ~w_rx_empty;
  assign w_rx_wr_ok = w_rx_push & (~w_rx_full | w_rx_rd);
  assign w_tx_rd   = w_do_rise & r_pend_pop;
  assign w_len_nxt = w_rx_usedw + CW'(w_rx_wr_ok) - CW'(w_rx_rd);

  // Transfer control, error flags and message status.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_bitcnt       <= 3'd0;
      r_armed        <= 1'b0;
      r_pend_pop     <= 1'b0;
      r_pend_unr     <= 1'b0;
      r_frame_pushed <= 1'b0;
      r_frame_done   <= 1'b0;
      r_miso_en      <= 1'b0;
      r_err_ovf      <= 1'b0;
      r_err_unr      <= 1'b0;
      r_have_msg     <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_start) begin
        r_bitcnt       <= 3'd0;
        r_armed        <= 1'b0;
        r_frame_pushed <= 1'b0;
        r_miso_en      <= 1'b1;
      end
      if (w_load) begin
        r_pend_pop <= ~w_tx_empty;
        r_pend_unr <= w_tx_empty;
      end
      if (w_do_rise) begin
        r_bitcnt   <= r_bitcnt + 1'b1;
        r_armed    <= 1'b1;
        r_pend_pop <= 1'b0;
        r_pend_unr <= 1'b0;
        if (r_pend_unr)                r_err_unr      <= 1'b1;
        if (w_rx_push)                 r_frame_pushed <= 1'b1;
        if (w_rx_push && !w_rx_wr_ok)  r_err_ovf      <= 1'b1;
      end
      if (w_end) begin
        r_miso_en    <= 1'b0;
        r_pend_pop   <= 1'b0;
        r_pend_unr   <= 1'b0;
        r_frame_done <= r_frame_pushed;
      end
      if (w_len_nxt == '0)   r_have_msg <= 1'b0;
      else if (r_frame_done) r_have_msg <= 1'b1;
    end
  end

  // Shift registers: data only, qualified by the control strobes.
  always_ff @(posedge clk) begin
    if (w_load)         r_tx_sr <= w_tx_empty ? FILL : w_tx_head;
    else if (w_do_fall) r_tx_sr <= {r_tx_sr[SPI_BYTE_W-2:0], 1'b0};
    if (w_do_rise)      r_rx_sr <= w_rx_byte;
  end

  fifo_sync #(.DATA_W(SPI_BYTE_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_wrreq (w_rx_push),
    .i_din   (w_rx_byte),
    .i_rdreq (rx_rdreq),
    .o_dout  (rx_dout),
    .o_empty (w_rx_empty),
    .o_full  (w_rx_full),
    .o_usedw (w_rx_usedw)
  );

  fifo_sync #(.DATA_W(SPI_BYTE_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_wrreq (tx_wrreq),
    .i_din   (tx_din),
    .i_rdreq (w_tx_rd),
    .o_dout  (w_tx_head),
    .o_empty (w_tx_empty),
    .o_full  (tx_full),
    .o_usedw (w_tx_usedw)
  );

  assign w_unused = &{1'b0, w_tx_usedw};

  assign miso     = r_miso_en ? r_tx_sr[SPI_BYTE_W-1] : 1'bz;
  assign len      = 8'(w_rx_usedw);
  assign have_msg = r_have_msg;
  assign err      = {r_err_unr, r_err_ovf};

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: table of frame scenarios plus hand-written sequences,
// with RX and MISO expectations held in scoreboard queues.
module tb_spi_slave_if;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int         DEPTH = 16;
  localparam logic [7:0] FILL  = 8'h00;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       sclk;
  logic       n_cs;
  logic       mosi;
  wire        miso;
  logic [7:0] tx_din;
  logic       tx_wrreq;
  logic       tx_full;
  logic [7:0] rx_dout;
  logic       rx_rdreq;
  logic       have_msg;
  logic [7:0] len;
  logic [1:0] err;

  // Released MISO reads as 1; the last byte loaded before n_cs rises is
  // always FILL (00), so a driver left enabled shows up as 0.
  pullup (miso);

  spi_slave_if #(.DEPTH(DEPTH), .FILL(FILL)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .sclk     (sclk),
    .n_cs     (n_cs),
    .mosi     (mosi),
    .miso     (miso),
    .tx_din   (tx_din),
    .tx_wrreq (tx_wrreq),
    .tx_full  (tx_full),
    .rx_dout  (rx_dout),
    .rx_rdreq (rx_rdreq),
    .have_msg (have_msg),
    .len      (len),
    .err      (err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] m_tx [0:31];

  typedef struct {
    int         nbytes;
    int         extra;
    int         npre;
    logic [7:0] pre_base;
    logic [7:0] mosi_base;
    int         half;
    int         exp_len;
    logic [1:0] exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0; sclk = 1'b0; n_cs = 1'b1; mosi = 1'b0;
    tx_wrreq = 1'b0; rx_rdreq = 1'b0; tx_din = 8'h00;
    wclk(2);
    n_rst = 1'b1;
    wclk(2);
    rxq.delete();
    txq.delete();
  endtask

  task automatic preload(input logic [7:0] v);
    tx_din = v; tx_wrreq = 1'b1;
    wclk(1);
    tx_wrreq = 1'b0;
    if (txq.size() < DEPTH) txq.push_back(v);
  endtask

  // Master side of one frame: nbytes full bytes from m_tx, then 'extra' bits.
  task automatic frame(input int nbytes, input int extra, input int h);
    logic [7:0] cap;
    logic [7:0] exp;
    n_cs = 1'b0;
    wclk(h);
    for (int i = 0; i < nbytes; i++) begin
      for (int b = 7; b >= 0; b--) begin
        mosi = m_tx[i][b];
        wclk(h);
        sclk = 1'b1;
        cap[b] = miso;
        wclk(h);
        sclk = 1'b0;
      end
      exp = (txq.size() > 0) ? txq.pop_front() : FILL;
      check("miso_byte", cap, exp);
      if (rxq.size() < DEPTH) rxq.push_back(m_tx[i]);
    end
    for (int b = 7; b > 7 - extra; b--) begin
      mosi = m_tx[nbytes][b];
      wclk(h);
      sclk = 1'b1;
      wclk(h);
      sclk = 1'b0;
    end
    wclk(h);
    n_cs = 1'b1;
    wclk(h + 4);
  endtask

  task automatic drain();
    int n;
    n = rxq.size();
    for (int i = 0; i < n; i++) begin
      check("len_before_read", len, n - i);
      check("rx_dout", rx_dout, rxq.pop_front());
      rx_rdreq = 1'b1;
      wclk(1);
      rx_rdreq = 1'b0;
      check("have_msg_drain", have_msg, (i == n - 1) ? 0 : 1);
    end
    check("len_drained", len, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{nbytes: 6,  extra: 0, npre: 0,  pre_base: 8'h00, mosi_base: 8'h01, half: 5, exp_len: 6,  exp_err: 2'b10};
    vecs[1] = '{nbytes: 4,  extra: 0, npre: 4,  pre_base: 8'h0A, mosi_base: 8'hA0, half: 5, exp_len: 4,  exp_err: 2'b00};
    vecs[2] = '{nbytes: 3,  extra: 0, npre: 1,  pre_base: 8'h55, mosi_base: 8'h30, half: 5, exp_len: 3,  exp_err: 2'b10};
    vecs[3] = '{nbytes: 17, extra: 3, npre: 0,  pre_base: 8'h00, mosi_base: 8'h40, half: 5, exp_len: 16, exp_err: 2'b11};
    vecs[4] = '{nbytes: 17, extra: 0, npre: 17, pre_base: 8'h80, mosi_base: 8'h11, half: 4, exp_len: 16, exp_err: 2'b11};

    // Reset state
    do_reset();
    check("rst_len", len, 0);
    check("rst_have_msg", have_msg, 0);
    check("rst_err", err, 0);
    check("rst_tx_full", tx_full, 0);
    check("rst_rx_dout", rx_dout, 0);
    check("rst_miso_idle", miso, 1);

    // Reset in the middle of a byte (TX empty, so err[1] is already set)
    n_cs = 1'b0;
    wclk(5);
    for (int b = 0; b < 4; b++) begin
      mosi = b[0]; wclk(5); sclk = 1'b1; wclk(5); sclk = 1'b0;
    end
    n_rst = 1'b0;
    #1;
    check("midrst_miso", miso, 1);
    check("midrst_len", len, 0);
    check("midrst_have_msg", have_msg, 0);
    check("midrst_err", err, 0);
    sclk = 1'b0; n_cs = 1'b1;
    wclk(3);
    n_rst = 1'b1;
    wclk(3);
    rxq.delete(); txq.delete();

    // Two back-to-back frames without draining: have_msg stays up
    m_tx[0] = 8'hDE; m_tx[1] = 8'hAD;
    frame(2, 0, 5);
    check("frameA_len", len, 2);
    check("frameA_have_msg", have_msg, 1);
    m_tx[0] = 8'hBE; m_tx[1] = 8'hEF;
    frame(2, 0, 5);
    check("frameB_len", len, 4);
    check("frameB_have_msg", have_msg, 1);
    drain();
    rx_rdreq = 1'b1;
    wclk(1);
    rx_rdreq = 1'b0;
    check("empty_read_len", len, 0);
    check("empty_read_err0", err[0], 0);

    // Table-driven scenarios
    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int p = 0; p < vecs[v].npre; p++) preload(8'(vecs[v].pre_base + p));
      if (vecs[v].npre >= DEPTH) check("tx_full", tx_full, 1);
      for (int i = 0; i <= vecs[v].nbytes; i++) m_tx[i] = 8'(vecs[v].mosi_base + i);
      frame(vecs[v].nbytes, vecs[v].extra, vecs[v].half);
      check("vec_len", len, vecs[v].exp_len);
      check("vec_have_msg", have_msg, 1);
      check("vec_err", err, vecs[v].exp_err);
      check("vec_miso_idle", miso, 1);
      drain();
    end

    // Random MOSI at the minimum sclk ratio
    do_reset();
    for (int f = 0; f < 100; f++) begin
      int nb;
      nb = $urandom_range(1, 3);
      for (int i = 0; i < nb; i++) m_tx[i] = 8'($urandom);
      frame(nb, 0, 4);
      check("rand_len", len, nb);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI responder (slave) for the far end of the multi-channel SPI master link; one instance per chip select.
- Oversamples sclk/n_cs/mosi in the local clk domain, deserialises MOSI bytes into an RX FIFO, and serialises bytes from a TX FIFO onto MISO.
- Presents the same message-oriented user interface as the master side: have_msg plus len for a complete received frame, and a byte write port for reply data.

Parameters:
- DEPTH, 16, entries in each of the RX and TX FIFOs (power of 2).
- FILL, 8'h00, byte shifted out on MISO when the TX FIFO is empty at a byte boundary.

Ports:
- clk  in  1  system clock; must run at ≥8× the sclk frequency.
- n_rst  in  1  asynchronous active-low reset.
- sclk  in  1  SPI clock from master; asynchronous to clk.
- n_cs  in  1  chip select from master, active low; asynchronous to clk.
- mosi  in  1  serial data from master.
- miso  out  1  serial data to master; 1'bz while n_cs is high.
- tx_din  in  8  reply byte.
- tx_wrreq  in  1  push tx_din into the TX FIFO; ignored when tx_full=1.
- tx_full  out  1  TX FIFO full.
- rx_dout  out  8  head of the RX FIFO (show-ahead).
- rx_rdreq  in  1  pop the RX FIFO; ignored when empty.
- have_msg  out  1  a complete frame is waiting in the RX FIFO.
- len  out  8  number of bytes currently in the RX FIFO.
- err  out  2  sticky flags: [0] RX overflow, [1] TX underrun; cleared only by reset.

Behaviour:
- Protocol: SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit bytes. MOSI is sampled on sclk rising; MISO changes on sclk falling.
- Input synchronisation: sclk, n_cs and mosi each pass through a 2-FF synchroniser plus one edge-detect register. Detection latency is 3 clk from a pin transition to the internal rise/fall strobe.
- Reset values: miso=z, tx_full=0, rx_dout=0, have_msg=0, len=0, err=0. The state machine enters IDLE and both FIFOs are emptied.
- State machine:
  - IDLE: n_cs synced high, miso=z. On the n_cs fall strobe, load the shift register from the TX FIFO head and pop it; if the TX FIFO is empty, load FILL and set err[1]. Drive MSB on miso the next clk, clear the bit counter, go to XFER.
  - XFER, sclk rise strobe: shift the synced mosi into rx_sr, increment the 3-bit bit counter. When the counter wraps 7→0, push rx_sr into the RX FIFO; if the RX FIFO is full, drop the byte and set err[0].
  - XFER, sclk fall strobe: shift tx_sr left and drive the new MSB. If the bit counter is 0 (byte boundary), reload tx_sr from the TX FIFO, or from FILL with err[1] set, and pop.
  - XFER, n_cs rise strobe: discard any partial byte (bit counter≠0), go to IDLE, miso=z. If at least one byte was pushed in this frame, set the frame-done flag.
- have_msg:
  - Asserts 1 clk after frame-done, provided len≠0.
  - Deasserts in the cycle len becomes 0 through reads.
  - Pushes during a new frame do not deassert it.
- len: equals the RX FIFO occupancy, saturating at DEPTH; updated 1 clk after a push or pop. A simultaneous push and pop leaves len unchanged.
- rx_rdreq with an empty RX FIFO has no effect, and no underflow is recorded.
- tx_wrreq during XFER is legal. The new byte is used at the next byte boundary if the FIFO had been empty.
- n_cs falling while sclk is high is a protocol violation: treat it as an ordinary frame start, and that sclk level is not counted as an edge.
- Timing requirements on the master: sclk half-period ≥4 clk, and n_cs fall to first sclk rise ≥4 clk.

Decomposition:
- Package spi_pkg holds: the state enum (IDLE, XFER), the SPI byte width (8), the synchroniser depth (2), and the default FILL value.
- One sub-module, fifo_sync: a single-clock show-ahead FIFO, parameterised by width and depth, with outputs empty/full/usedw. It is instantiated twice (RX and TX).

Test Plan:
- Reset mid-frame: assert n_rst after 4 bits of a byte → miso=z, len=0, have_msg=0, err=0 immediately; the next full frame is received correctly.
- Basic RX: master sends 8'h01..8'h06 in one frame at clk/10 → after n_cs rises, have_msg=1, len=6. Six rx_rdreq pops return 01..06, and have_msg drops in the cycle len reaches 0.
- Basic TX: preload 8'h0A,0B,0C,0D via tx_wrreq, then a 4-byte frame → master captures 0A 0B 0C 0D on MISO; err[1]=0, and miso=z after n_cs rises.
- Underrun: preload 1 byte 8'h55, then a 3-byte frame → MISO carries 55 00 00 and err[1]=1.
- Overflow and partial byte: DEPTH=16, master sends 17 bytes plus 3 extra bits → len=16, err[0]=1, first 16 bytes intact, partial bits discarded.
- Random MOSI at the minimum ratio (sclk half-period = 4 clk) over 100 frames: RX bytes match the transmitted stream bit-exactly.
